// File: rtl/klp32_boot_loader.sv
// klp32_boot_loader: loads a checksummed UART frame into IMEM and holds the core in reset until it verifies.
// Optional inter-byte timeout is enabled by defining KLP32_BOOT_TIMEOUT_EN.
module klp32_boot_loader #(
  parameter int IMEM_WORDS     = 256,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic        o_imem_we,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_wdata,
  output logic        o_core_reset,
  output logic        o_done,
  output logic        o_error,
  output logic [15:0] o_words_loaded
);
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR} state_t;
  localparam logic [16:0] max_words = 17'(IMEM_WORDS);
  state_t state, next;
  logic        fire, restart, expired;
  logic [7:0]  len_lo, csum;
  logic [15:0] len, idx, n;
  logic [1:0]  bcnt;
  logic [23:0] part;
  assign fire    = i_rx_valid && o_rx_ready;
  assign restart = fire && i_rx_data == 8'hA5 && (state == IDLE || state == ERROR);
  assign n       = {i_rx_data, len_lo};
`ifdef KLP32_BOOT_TIMEOUT_EN
  logic [31:0] tcnt;
  logic        active;
  assign active  = state inside {LEN_LO, LEN_HI, DATA, CSUM};
  assign expired = active && !fire && tcnt == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (reset || fire || !active) tcnt <= '0;
    else tcnt <= tcnt + 32'd1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expired = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    if (fire)
      case (state)
        IDLE, ERROR: next = (i_rx_data == 8'hA5) ? LEN_LO : state;
        LEN_LO:      next = LEN_HI;
        LEN_HI:      next = ({1'b0, n} > max_words) ? ERROR : (n == 16'd0) ? CSUM : DATA;
        DATA:        next = (bcnt == 2'd3 && idx + 16'd1 == len) ? CSUM : DATA;
        CSUM:        next = (i_rx_data == csum) ? DONE : ERROR;
        default:     next = state;
      endcase
    if (expired) next = ERROR;
  end
  always_comb begin
    o_rx_ready   = 1'b1;
    o_done       = state == DONE;
    o_error      = state == ERROR;
    o_core_reset = state != DONE;
  end
  // Bytes shift in from the top so the first three land in part[7:0], [15:8], [23:16].
  always_ff @(posedge clk) begin
    if (reset) begin
      o_imem_we      <= 1'b0;
      o_imem_addr    <= '0;
      o_imem_wdata   <= '0;
      o_words_loaded <= '0;
      len_lo         <= '0;
      len            <= '0;
      idx            <= '0;
      bcnt           <= '0;
      csum           <= '0;
      part           <= '0;
    end else begin
      o_imem_we <= 1'b0;
      if (restart) begin
        bcnt           <= '0;
        idx            <= '0;
        csum           <= '0;
        o_words_loaded <= '0;
      end
      if (fire && state == LEN_LO) len_lo <= i_rx_data;
      if (fire && state == LEN_HI) begin
        len  <= n;
        bcnt <= '0;
        idx  <= '0;
        csum <= '0;
      end
      if (fire && state == DATA) begin
        csum <= csum ^ i_rx_data;
        bcnt <= bcnt + 2'd1;
        part <= {i_rx_data, part[23:8]};
        if (bcnt == 2'd3) begin
          o_imem_we      <= 1'b1;
          o_imem_addr    <= {14'd0, idx, 2'b00};
          o_imem_wdata   <= {i_rx_data, part};
          idx            <= idx + 16'd1;
          o_words_loaded <= o_words_loaded + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_klp32_boot_loader.sv
// tb_klp32_boot_loader: vector table, corner sequences and random frames checked against a frame-level model.
module tb_klp32_boot_loader;
  localparam int MAXW = 256;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready, o_imem_we, o_core_reset, o_done, o_error;
  logic [31:0] o_imem_addr, o_imem_wdata;
  logic [15:0] o_words_loaded;
  klp32_boot_loader #(.IMEM_WORDS(MAXW), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_rx_ready(o_rx_ready), .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr),
    .o_imem_wdata(o_imem_wdata), .o_core_reset(o_core_reset), .o_done(o_done),
    .o_error(o_error), .o_words_loaded(o_words_loaded)
  );
  always #5 clk = ~clk;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    string       name;
    int          n;
    logic [95:0] b;
    bit          done;
    bit          err;
    int          wl;
    int          nwr;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;
  vec_t        tbl[4];
  int          tests = 0, fails = 0;
  logic [31:0] got_a[$], got_d[$], exp_a[$], exp_d[$];
  bq_t         q, good;
  logic [7:0]  bv, x;
  int          n, cyc;
  always @(negedge clk)
    if (o_imem_we === 1'b1) begin
      got_a.push_back(o_imem_addr);
      got_d.push_back(o_imem_wdata);
    end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] at(input logic [31:0] qq[$], input int k);
    return k < qq.size() ? qq[k] : 'x;
  endfunction
  function automatic bq_t mk(input logic [95:0] b, input int cnt);
    bq_t r = {};
    for (int k = 0; k < cnt; k++) r.push_back(b[95-8*k -: 8]);
    return r;
  endfunction
  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'($urandom);
  endtask
  task automatic send_all(input bq_t b, input int lo, input int hi);
    foreach (b[k]) send(b[k], $urandom_range(hi, lo));
  endtask
  task automatic do_reset();
    reset      = 1'b1;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    got_a = {};
    got_d = {};
  endtask
  task automatic chk_reset(input string tag);
    check({tag, " rx_ready"}, 32'(o_rx_ready), 32'd1);
    check({tag, " we"}, 32'(o_imem_we), 32'd0);
    check({tag, " addr"}, o_imem_addr, 32'd0);
    check({tag, " wdata"}, o_imem_wdata, 32'd0);
    check({tag, " core_reset"}, 32'(o_core_reset), 32'd1);
    check({tag, " done"}, 32'(o_done), 32'd0);
    check({tag, " error"}, 32'(o_error), 32'd0);
    check({tag, " words"}, 32'(o_words_loaded), 32'd0);
  endtask
  // Frame-level model: scan for magic, take length, words, checksum; restart on magic after an error.
  task automatic model(input bq_t b, output bit done, output bit err, output int wl);
    int          i = 0;
    int          len;
    bit          stall = 0;
    logic [7:0]  sum;
    logic [31:0] w;
    exp_a = {};
    exp_d = {};
    done  = 0;
    err   = 0;
    wl    = 0;
    while (i < b.size() && !done && !stall) begin
      if (b[i] != 8'hA5) begin
        i++;
        continue;
      end
      i++;
      err = 0;
      wl  = 0;
      if (i + 2 > b.size()) begin
        stall = 1;
        continue;
      end
      len = int'({b[i+1], b[i]});
      i += 2;
      if (len > MAXW) begin
        err = 1;
        continue;
      end
      sum = 0;
      for (int k = 0; k < len && !stall; k++) begin
        if (i + 4 > b.size()) stall = 1;
        else begin
          w = {b[i+3], b[i+2], b[i+1], b[i]};
          exp_a.push_back(32'(k * 4));
          exp_d.push_back(w);
          sum ^= b[i] ^ b[i+1] ^ b[i+2] ^ b[i+3];
          wl++;
          i += 4;
        end
      end
      if (stall || i >= b.size()) begin
        stall = 1;
        continue;
      end
      if (b[i] == sum) done = 1;
      else err = 1;
      i++;
    end
  endtask
  task automatic compare_run(input string tag, input bq_t b);
    bit d, e;
    int wl;
    repeat (2) @(posedge clk);
    #1;
    model(b, d, e, wl);
    check({tag, " done"}, 32'(o_done), 32'(d));
    check({tag, " error"}, 32'(o_error), 32'(e));
    check({tag, " core_reset"}, 32'(o_core_reset), 32'(!d));
    check({tag, " words"}, 32'(o_words_loaded), 32'(wl));
    check({tag, " nwrites"}, 32'(got_d.size()), 32'(exp_d.size()));
    foreach (exp_d[k]) begin
      check($sformatf("%s addr%0d", tag, k), at(got_a, k), exp_a[k]);
      check($sformatf("%s data%0d", tag, k), at(got_d, k), exp_d[k]);
    end
  endtask
  initial begin
    tbl[0] = '{"good", 12, 96'hA502_0013_0550_0093_0740_0092, 1'b1, 1'b0, 2, 2, 32'h00500513, 32'h00400793};
    tbl[1] = '{"badsum", 12, 96'hA502_0013_0550_0093_0740_0093, 1'b0, 1'b1, 2, 2, 32'h00500513, 32'h00400793};
    tbl[2] = '{"oversize", 3, {24'hA50101, 72'h0}, 1'b0, 1'b1, 0, 0, 32'h0, 32'h0};
    tbl[3] = '{"empty", 6, {48'h00FFA5000000, 48'h0}, 1'b1, 1'b0, 0, 0, 32'h0, 32'h0};
    good = mk(tbl[0].b, 12);
    do_reset();
    chk_reset("reset");
    foreach (tbl[t]) begin
      q = mk(tbl[t].b, tbl[t].n);
      do_reset();
      send_all(q, 0, 0);
      compare_run(tbl[t].name, q);
      check({tbl[t].name, " tbl done"}, 32'(o_done), 32'(tbl[t].done));
      check({tbl[t].name, " tbl error"}, 32'(o_error), 32'(tbl[t].err));
      check({tbl[t].name, " tbl words"}, 32'(o_words_loaded), 32'(tbl[t].wl));
      check({tbl[t].name, " tbl nwr"}, 32'(got_d.size()), 32'(tbl[t].nwr));
      if (tbl[t].nwr == 2) begin
        check({tbl[t].name, " tbl w0"}, at(got_d, 0), tbl[t].w0);
        check({tbl[t].name, " tbl a1"}, at(got_a, 1), 32'd4);
        check({tbl[t].name, " tbl w1"}, at(got_d, 1), tbl[t].w1);
      end
    end
    do_reset();
    for (int k = 0; k < 11; k++) send(good[k], 0);
    check("pre-csum done", 32'(o_done), 32'd0);
    check("pre-csum core_reset", 32'(o_core_reset), 32'd1);
    send(good[11], 0);
    check("post-csum done", 32'(o_done), 32'd1);
    check("post-csum core_reset", 32'(o_core_reset), 32'd0);
    do_reset();
    q = mk(tbl[1].b, 12);
    send_all(q, 0, 0);
    check("bad then good err", 32'(o_error), 32'd1);
    send_all(good, 0, 1);
    foreach (good[k]) q.push_back(good[k]);
    compare_run("bad then good", q);
    do_reset();
    send(8'hA5, 0);
    send(8'h01, 0);
    check("oversize pre", 32'(o_error), 32'd0);
    send(8'h01, 0);
    check("oversize immediate", 32'(o_error), 32'd1);
    do_reset();
    send_all(good, 3, 3);
    compare_run("gap3", good);
    do_reset();
    q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05};
    send_all(q, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("midword");
    reset = 1'b0;
    got_a = {};
    got_d = {};
    send_all(good, 0, 0);
    compare_run("after midword", good);
    do_reset();
    q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
    send_all(q, 0, 0);
    i_rx_data  = 8'h44;
    i_rx_valid = 1'b1;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
    reset      = 1'b0;
    check("cancel we", 32'(o_imem_we), 32'd0);
    check("cancel words", 32'(o_words_loaded), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("cancel nwrites", 32'(got_d.size()), 32'd0);
    for (int r = 0; r < 20; r++) begin
      q = {};
      repeat ($urandom_range(3, 0)) begin
        bv = 8'($urandom);
        q.push_back(bv == 8'hA5 ? 8'h5A : bv);
      end
      n = ($urandom_range(7, 0) == 0) ? 257 + $urandom_range(50, 0) : $urandom_range(5, 0);
      q.push_back(8'hA5);
      q.push_back(8'(n));
      q.push_back(8'(n >> 8));
      if (n <= MAXW) begin
        x = 0;
        repeat (4 * n) begin
          bv = 8'($urandom);
          x ^= bv;
          q.push_back(bv);
        end
        q.push_back(x ^ (($urandom_range(3, 0) == 0) ? 8'(1 << $urandom_range(7, 0)) : 8'h00));
      end
      repeat ($urandom_range(3, 0)) q.push_back(8'($urandom));
      do_reset();
      send_all(q, 0, 2);
      compare_run($sformatf("rnd%0d", r), q);
    end
`ifdef KLP32_BOOT_TIMEOUT_EN
    do_reset();
    send(8'hA5, 0);
    send(8'h02, 0);
    cyc = 0;
    while (o_error !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("timeout cycles", 32'(cyc), 32'd50);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/klp32_boot_loader.md
Name: klp32_boot_loader

Overview:
- Sits upstream of the KLP32V1 core. Receives a program image as a byte stream from the UART RX block.
- Assembles little-endian 32-bit words and writes them into instruction memory through its write port.
- Holds the core in reset until a complete frame with a valid checksum has been loaded, then releases it.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in words; maximum accepted word count.
- TIMEOUT_CYCLES, 100000, inter-byte timeout in clk cycles; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- i_rx_data  input  8  received byte.
- i_rx_valid  input  1  i_rx_data valid this cycle.
- o_rx_ready  output  1  loader accepts a byte; a byte transfers when i_rx_valid && o_rx_ready.
- o_imem_we  output  1  instruction memory write strobe, one-cycle pulse per word.
- o_imem_addr  output  32  byte address of the write; always word aligned.
- o_imem_wdata  output  32  word to write.
- o_core_reset  output  1  reset to the core; high while loading.
- o_done  output  1  image loaded and verified.
- o_error  output  1  frame error (bad magic is ignored, not an error).
- o_words_loaded  output  16  count of words written in the current frame.

Behaviour:
- Frame format: magic 0xA5; LEN_LO; LEN_HI (word count N); N×4 data bytes, each word LSB first; CSUM byte.
- CSUM = XOR of all data bytes only.
- Reset values: o_rx_ready=1, o_imem_we=0, o_imem_addr=0, o_imem_wdata=0, o_core_reset=1, o_done=0, o_error=0, o_words_loaded=0, state=IDLE.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR.
- IDLE: 0xA5 -> LEN_LO; any other byte is dropped and the state stays IDLE.
- LEN_LO -> LEN_HI on the next byte.
- LEN_HI on the next byte:
  - N > IMEM_WORDS -> ERROR.
  - N == 0 -> CSUM.
  - otherwise -> DATA; byte counter = 0, word index = 0, running XOR = 0.
- DATA:
  - Each byte shifts into bits [8k+7:8k], k = byte counter 0..3, and XORs into the running checksum.
  - On the 4th byte: the next cycle asserts o_imem_we for exactly one cycle, with o_imem_addr = index×4 and o_imem_wdata = the assembled word.
  - index and o_words_loaded increment on that same cycle.
  - After word N-1 is accepted -> CSUM.
- CSUM:
  - Byte == running XOR -> DONE.
  - Otherwise -> ERROR.
- DONE:
  - o_done=1 and o_core_reset=0, both starting the cycle after the checksum byte is accepted.
  - o_rx_ready stays 1; all bytes are ignored. Only reset leaves DONE.
- ERROR:
  - o_error=1 and o_core_reset=1.
  - A 0xA5 byte clears o_error and restarts the frame (-> LEN_LO, counters cleared). Other bytes are ignored.
- o_rx_ready is 1 in every state; the loader never back-pressures. It accepts at most one byte per cycle.
- Words already written before an error stay in memory; the core stays in reset.
- i_rx_valid without a transfer has no effect. Partial-word state is held indefinitely while no bytes arrive.
- Reset in any state, including mid-word, returns everything to reset values on the next edge. Any pending write strobe is cancelled.

Optional Feature:
- Macro: KLP32_BOOT_TIMEOUT_EN.
- Defined:
  - A counter clears on every accepted byte and increments each cycle while in LEN_LO, LEN_HI, DATA or CSUM.
  - When it reaches TIMEOUT_CYCLES -> ERROR with o_error=1.
  - The counter is idle in IDLE, DONE and ERROR.
- Not defined: no counter; a stalled frame waits forever. TIMEOUT_CYCLES is unused.

Test Plan:
- Good frame: bytes A5 02 00 13 05 50 00 93 07 40 00 92, back-to-back.
  - Required: two write pulses — addr 0x0 data 0x00500513, then addr 0x4 data 0x00400793.
  - Required: o_words_loaded=2; o_done=1 and o_core_reset=0 one cycle after the 0x92 byte.
- Bad checksum: same frame with last byte 0x93.
  - Required: both writes occur; o_error=1, o_core_reset=1, o_done=0.
  - Then send a fresh good frame -> o_error clears and o_done=1.
- Oversize frame: A5 01 01 (N=257 > 256).
  - Required: ERROR immediately after LEN_HI; no o_imem_we pulse.
- Empty frame plus noise: 00 FF A5 00 00 00.
  - Required: leading bytes ignored; no writes; o_done=1.
- Gaps and reset:
  - Good frame with i_rx_valid low for 3 random cycles between bytes -> identical writes.
  - Assert reset after 2 data bytes -> all outputs return to reset values; the next good frame loads correctly.
- With KLP32_BOOT_TIMEOUT_EN and TIMEOUT_CYCLES=50: stall after A5 02 -> o_error=1 exactly 50 cycles after the last accepted byte.
